// File: rtl/enigma_pkg.sv
// Shared constants and state encoding for the Enigma rotor sequencer slice.
package enigma_pkg;

    localparam int ALPHABET     = 26;
    localparam int LETTER_W     = 5;
    localparam int PASSTHRU_MIN = ALPHABET;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STEP      = 3'd1,
        ST_DRIVE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_OUTPUT    = 3'd4
    } seq_state_e;

    // Codes at or above PASSTHRU_MIN bypass the rotor untouched.
    function automatic logic is_passthru(input logic [LETTER_W-1:0] code);
        return ({{(32-LETTER_W){1'b0}}, code} >= PASSTHRU_MIN[31:0]);
    endfunction

endpackage

// File: rtl/rotor_step_counter.sv
// Mod-ALPHABET rotor position register with synchronous load, step enable
// and a notch carry pulse, reusable for cascaded rotor stages.
module rotor_step_counter #(
    parameter int ALPHABET = 26,
    parameter int NOTCH    = 16,
    parameter int W        = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    output logic [W-1:0] position_o,
    output logic [W-1:0] next_pos_o,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST_POS = W'(ALPHABET - 1);
    localparam logic [W-1:0] NOTCH_POS = W'(NOTCH);

    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;

    assign next_pos_o = (pos_q == LAST_POS) ? {W{1'b0}} : pos_q + {{(W-1){1'b0}}, 1'b1};
    assign position_o = pos_q;
    // Carry is tied to the step itself so it lasts exactly the stepping cycle.
    assign carry_o    = step_i & (pos_q == NOTCH_POS);

    // Next position: load wins over step.
    always_comb begin
        pos_d = pos_q;
        if (load_i) begin
            pos_d = load_val_i;
        end else if (step_i) begin
            pos_d = next_pos_o;
        end else begin
            pos_d = pos_q;
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= {W{1'b0}};
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/enigma_rotor_sequencer.sv
// Per-character controller: steps the rotor, drives the rotor0+reflector
// datapath, waits for done with a timeout and returns the result.
module enigma_rotor_sequencer
    import enigma_pkg::*;
#(
    parameter int ALPHABET       = enigma_pkg::ALPHABET,
    parameter int NOTCH          = 16,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [LETTER_W-1:0] cfg_position,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [LETTER_W-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [LETTER_W-1:0] out_data,
    output logic                out_err,
    input  logic                out_ready,
    output logic [LETTER_W-1:0] rot_data_in,
    output logic [LETTER_W-1:0] rot_position,
    input  logic [LETTER_W-1:0] rot_data_out,
    input  logic                rot_done,
    output logic                carry_out,
    output logic [LETTER_W-1:0] cur_position,
    output logic                busy
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LETTER_W-1:0] ALPHA_L    = LETTER_W'(ALPHABET);
    localparam logic [SET_W-1:0]    SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_END    = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_e          state_q, state_d;
    logic [LETTER_W-1:0] char_q, char_d;
    logic [LETTER_W-1:0] out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
    logic [LETTER_W-1:0] rot_data_q, rot_data_d;
    logic [LETTER_W-1:0] rot_pos_q, rot_pos_d;
    logic                cfg_err_q, cfg_err_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rdy_en_q;
    logic                out_valid_q, busy_q;
    logic                in_ready_s, load_s, step_s;
    logic [LETTER_W-1:0] pos_s, next_pos_s;

    rotor_step_counter #(
        .ALPHABET (ALPHABET),
        .NOTCH    (NOTCH),
        .W        (LETTER_W)
    ) u_rotor (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .load_val_i (cfg_position),
        .step_i     (step_s),
        .position_o (pos_s),
        .next_pos_o (next_pos_s),
        .carry_o    (carry_out)
    );

    // Next-state and datapath-control decode.
    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        rot_data_d = rot_data_q;
        rot_pos_d  = rot_pos_q;
        cfg_err_d  = cfg_err_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        in_ready_s = 1'b0;
        load_s     = 1'b0;
        step_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = rdy_en_q & ~cfg_load;
                if (cfg_load) begin
                    if (cfg_position < ALPHA_L) begin
                        load_s    = 1'b1;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (in_valid && rdy_en_q) begin
                    char_d  = in_data;
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // char_q is first visible here, so the pass-through decision lives in STEP.
            ST_STEP: begin
                if (!is_passthru(char_q)) begin
                    step_s     = 1'b1;
                    rot_data_d = char_q;
                    rot_pos_d  = next_pos_s;
                    settle_d   = {SET_W{1'b0}};
                    state_d    = ST_DRIVE;
                end else begin
                    out_data_d = char_q;
                    out_err_d  = 1'b0;
                    state_d    = ST_OUTPUT;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_END) begin
                    tmo_d   = {TMO_W{1'b0}};
                    state_d = ST_WAIT_DONE;
                end else begin
                    settle_d = settle_q + {{(SET_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_DONE: begin
                if (rot_done) begin
                    out_data_d = rot_data_out;
                    out_err_d  = 1'b0;
                    state_d    = ST_OUTPUT;
                end else if (tmo_q == TMO_END) begin
                    out_data_d = char_q;
                    out_err_d  = 1'b1;
                    state_d    = ST_OUTPUT;
                end else begin
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; rdy_en_q holds in_ready low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            char_q      <= {LETTER_W{1'b0}};
            out_data_q  <= {LETTER_W{1'b0}};
            out_err_q   <= 1'b0;
            rot_data_q  <= {LETTER_W{1'b0}};
            rot_pos_q   <= {LETTER_W{1'b0}};
            cfg_err_q   <= 1'b0;
            settle_q    <= {SET_W{1'b0}};
            tmo_q       <= {TMO_W{1'b0}};
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            char_q      <= char_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            rot_data_q  <= rot_data_d;
            rot_pos_q   <= rot_pos_d;
            cfg_err_q   <= cfg_err_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            rdy_en_q    <= 1'b1;
            out_valid_q <= (state_d == ST_OUTPUT);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign rot_data_in  = rot_data_q;
    assign rot_position = rot_pos_q;
    assign cfg_err      = cfg_err_q;
    assign cur_position = pos_s;
    assign busy         = busy_q;

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Scoreboard bench for enigma_rotor_sequencer with a rotor datapath stub.
module tb_enigma_rotor_sequencer;

    logic       clk, rst_n;
    logic       cfg_load, cfg_err;
    logic [4:0] cfg_position;
    logic       in_valid, in_ready;
    logic [4:0] in_data;
    logic       out_valid, out_err, out_ready;
    logic [4:0] out_data;
    logic [4:0] rot_data_in, rot_position, rot_data_out;
    logic       rot_done, carry_out, busy;
    logic [4:0] cur_position;

    typedef struct packed {
        logic [4:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_pos = 0;
    int   carry_cnt = 0;
    logic stall = 1'b0;
    logic [9:0] prev_in;
    logic [5:0] sum_s;

    enigma_rotor_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_load     (cfg_load),
        .cfg_position (cfg_position),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_err      (out_err),
        .out_ready    (out_ready),
        .rot_data_in  (rot_data_in),
        .rot_position (rot_position),
        .rot_data_out (rot_data_out),
        .rot_done     (rot_done),
        .carry_out    (carry_out),
        .cur_position (cur_position),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stub: (data+position) mod 26, done one cycle after inputs change.
    always @(posedge clk) prev_in <= {rot_data_in, rot_position};
    assign sum_s        = {1'b0, rot_data_in} + {1'b0, rot_position};
    assign rot_data_out = (sum_s >= 6'd26) ? 5'(sum_s - 6'd26) : sum_s[4:0];
    assign rot_done     = ~stall & ({rot_data_in, rot_position} == prev_in);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output side of the scoreboard: compare at each result handshake.
    always @(negedge clk) begin
        if (carry_out) carry_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic do_cfg(input logic [4:0] p, input logic exp_err);
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_position = p;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        if (!exp_err) model_pos = int'(p);
        @(negedge clk);
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
        chk("cfg_pos", 32'(cur_position), 32'(model_pos));
    endtask

    task automatic wait_out(input int lat);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        chk("latency", 32'(n), 32'(lat));
    endtask

    task automatic run_letter(input logic [4:0] d, input int lat, input bit hold);
        exp_t       e;
        int         exp_carry;
        logic [4:0] rdi_b, rp_b, held;
        logic       cfg_err_b;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; out_ready = !hold; carry_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        rdi_b = rot_data_in; rp_b = rot_position;
        if (d < 5'd26) begin
            exp_carry = (model_pos == 16) ? 1 : 0;
            model_pos = (model_pos == 25) ? 0 : model_pos + 1;
            e.data    = stall ? d : 5'((int'(d) + model_pos) % 26);
            e.err     = stall;
        end else begin
            exp_carry = 0;
            e.data    = d;
            e.err     = 1'b0;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1 in_valid = 1'b0;
        wait_out(lat);
        if (hold) begin
            held = out_data;
            cfg_err_b = cfg_err;
            cfg_load = 1'b1; cfg_position = 5'd7;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            cfg_load = 1'b0;
            chk("busy_cfg_err", 32'(cfg_err), 32'(cfg_err_b));
            @(posedge clk); #1 out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("position", 32'(cur_position), 32'(model_pos));
        chk("carry_pulses", 32'(carry_cnt), 32'(exp_carry));
        if (d >= 5'd26) begin
            chk("pt_rot_data", 32'(rot_data_in), 32'(rdi_b));
            chk("pt_rot_pos", 32'(rot_position), 32'(rp_b));
        end
    endtask

    initial begin
        int ov;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_position = 5'd0;
        in_valid = 1'b0; in_data = 5'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", 32'(cur_position), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_rot_data", 32'(rot_data_in), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        do_cfg(5'd3, 1'b0);
        run_letter(5'd0, 4, 1'b0);
        run_letter(5'd7, 4, 1'b0);
        do_cfg(5'd25, 1'b0);
        run_letter(5'd10, 4, 1'b0);
        do_cfg(5'd16, 1'b0);
        run_letter(5'd3, 4, 1'b0);
        run_letter(5'd27, 2, 1'b0);
        run_letter(5'd31, 2, 1'b0);
        stall = 1'b1;
        run_letter(5'd9, 18, 1'b0);
        stall = 1'b0;
        run_letter(5'd5, 4, 1'b1);
        do_cfg(5'd30, 1'b1);
        do_cfg(5'd2, 1'b0);

        // cfg_load and in_valid together: config first, letter next cycle.
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_position = 5'd12; in_valid = 1'b1; in_data = 5'd4;
        @(negedge clk);
        chk("cfg_prio_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 cfg_load = 1'b0;
        @(negedge clk);
        chk("cfg_prio_pos", 32'(cur_position), 32'd12);
        chk("cfg_prio_busy", 32'(busy), 32'd0);
        chk("cfg_prio_ready_next", 32'(in_ready), 32'd1);
        model_pos = 13;
        @(posedge clk);
        exp_q.push_back('{data: 5'd17, err: 1'b0});
        #1 in_valid = 1'b0;
        wait_out(4);
        @(posedge clk);
        @(negedge clk);
        chk("cfg_prio_final_pos", 32'(cur_position), 32'd13);

        // Reset while the datapath is being driven.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 5'd1;
        @(negedge clk);
        chk("rd_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drive_rot_data", 32'(rot_data_in), 32'd1);
        chk("drive_rot_pos", 32'(rot_position), 32'd14);
        chk("drive_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rd_busy", 32'(busy), 32'd0);
        chk("rd_pos", 32'(cur_position), 32'd0);
        chk("rd_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_pos = 0;
        ov = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("rd_no_out_valid", 32'(ov), 32'd0);
        run_letter(5'd6, 4, 1'b0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_sequencer.md
Name: enigma_rotor_sequencer

Overview:
- Per-character controller for the rotor0 + reflector datapath.
- Accepts 5-bit letter codes over a valid/ready handshake and steps the rotor position before each letter, as in the Enigma ordering.
- Drives the datapath, waits for its done flag with a timeout, and returns the result over a second valid/ready handshake.
- Also owns rotor position configuration, and emits a notch carry pulse for cascading to a next rotor stage.

Parameters:
- ALPHABET, 26, number of valid letter codes (0..ALPHABET-1).
- NOTCH, 16, position at which stepping emits carry_out.
- SETTLE_CYCLES, 1, cycles the datapath inputs are held before done is sampled (≥1).
- TIMEOUT_CYCLES, 15, max WAIT_DONE cycles before an error completion (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_load  in  1  load cfg_position (honoured only in IDLE).
- cfg_position  in  5  new rotor position.
- cfg_err  out  1  sticky: last cfg_load was out of range (cleared by the next valid load).
- in_valid  in  1  input letter valid.
- in_data  in  5  input letter code.
- in_ready  out  1  sequencer can accept a letter.
- out_valid  out  1  result valid.
- out_data  out  5  result letter code.
- out_err  out  1  qualifies out_data: datapath timed out.
- out_ready  in  1  downstream accepts the result.
- rot_data_in  out  5  to datapath data_in.
- rot_position  out  5  to datapath position.
- rot_data_out  in  5  from datapath data_out.
- rot_done  in  1  from datapath done_out.
- carry_out  out  1  one-cycle pulse when stepping from NOTCH.
- cur_position  out  5  current rotor position.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, position=0.
  - All outputs 0, except in_ready, which follows IDLE rules once rst_n=1.
  - Reset mid-operation aborts the letter; no out_valid is produced.
- States: IDLE, STEP, DRIVE, WAIT_DONE, OUTPUT.
- IDLE:
  - in_ready = ~cfg_load.
  - cfg_load has priority over in_valid in the same cycle.
  - If cfg_position < ALPHABET: load it and clear cfg_err. Otherwise position is unchanged and cfg_err=1.
  - On in_valid & in_ready, latch in_data into char_q.
  - If char_q < ALPHABET go to STEP; otherwise go directly to OUTPUT with out_data=char_q (pass-through, no step, out_err=0).
- STEP (1 cycle):
  - position <= (position==ALPHABET-1) ? 0 : position+1.
  - carry_out=1 this cycle iff the old position==NOTCH.
- DRIVE (SETTLE_CYCLES cycles):
  - rot_data_in=char_q, rot_position=position (new value).
  - rot_data_in and rot_position hold these values through WAIT_DONE.
- WAIT_DONE:
  - Sample rot_done each cycle.
  - If rot_done=1: capture rot_data_out into out_data, out_err=0, go to OUTPUT.
  - If TIMEOUT_CYCLES elapse without done: out_data=char_q, out_err=1, go to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data and out_err are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE next cycle. in_ready rises that cycle, so there is no same-cycle turnaround.
- Latency with SETTLE_CYCLES=1 and rot_done already high:
  - Handshake at T; STEP T+1; DRIVE T+2; WAIT_DONE T+3; out_valid at T+4.
  - Throughput is 1 letter per 5 cycles with out_ready held high.
- Widths:
  - position is always < ALPHABET; the counter is 5 bits.
  - The timeout counter is clog2(TIMEOUT_CYCLES+1) bits and is cleared on entry to WAIT_DONE.
- cur_position always reflects the registered position; busy=1 outside IDLE.
- Inputs other than rst_n are ignored outside their states (cfg_load while busy has no effect, cfg_err unchanged).

Decomposition:
- Shared package enigma_pkg:
  - ALPHABET and the letter-code width (5).
  - State enumeration constants.
  - PASSTHRU_MIN = ALPHABET.
- One natural sub-module: rotor_step_counter. It holds the mod-ALPHABET position register, synchronous load, step enable and carry pulse. It is reusable for later cascaded rotors.

Test Plan:
(Bench datapath stub: rot_data_out = (rot_data_in + rot_position) mod 26, with rot_done high 1 cycle after its inputs change.)
- Reset, cfg_load with cfg_position=3, then send in_data=0 → rotor steps to 4; out_data=4, out_err=0, out_valid at T+4, cur_position=4.
- Position 25, in_data=10 → position wraps to 0, out_data=10. With position=16 (NOTCH) → carry_out pulses exactly one cycle, in STEP.
- in_data=27 → out_data=27 with no step (cur_position unchanged) and no rot_* activity change; out_valid at T+2.
- Stub holds rot_done=0 → after 15 WAIT_DONE cycles, out_valid=1, out_err=1, out_data=in_data.
- out_ready low for 10 cycles → out_valid and out_data held stable, in_ready=0. cfg_load issued while busy → ignored.
- cfg_load with cfg_position=30 → cfg_err=1, position unchanged. cfg_load and in_valid in the same IDLE cycle → config taken, in_ready=0, letter accepted next cycle. rst_n pulsed low during DRIVE → IDLE, position=0, no out_valid.
